mem_stage_dcache: RTL and testbench
===================================

// Module: mem_stage_dcache
// PURPOSE
//  MEM-stage data cache. Consumes the EX/MEM register's memory controls, address and store data.
//  Produces data_hit, which is the stall/advance enable for the EX/MEM register (1 = pipeline advances).
//  Direct-mapped, write-through, no-write-allocate; misses are refilled from main memory over a req/ready handshake.
// PARAMETERS
//  INDEX_BITS      4   number of line-index bits (2**INDEX_BITS lines)
//  OFFSET_BITS     2   word-offset bits per line (WORDS_PER_LINE = 2**OFFSET_BITS)
//  ADDR_W          32  byte-address width
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  m_ctl      in   3       [2]=branch (ignored), [1]=memread, [0]=memwrite
//  addr       in   ADDR_W  byte address (alu_result); addr[1:0] ignored
//  wdata      in   32      store data (rdata2out)
//  data_hit   out  1       1 = access complete or no access; 0 = stall
//  rdata      out  32      load data; valid when data_hit=1 and memread=1
//  mem_req    out  1       memory beat request
//  mem_we     out  1       1 = write beat, 0 = read beat
//  mem_addr   out  ADDR_W  word-aligned beat address
//  mem_wdata  out  32      write beat data
//  mem_rdata  in   32      read data, valid in the cycle mem_ready=1
//  mem_ready  in   1       beat completes on a cycle with mem_req=1 && mem_ready=1
// BEHAVIOUR
//  Address split: offset=addr[OFFSET_BITS+1:2], index=next INDEX_BITS, tag=remaining upper bits.
//  Inputs are held stable by the upstream stage while data_hit=0.
//  Reset: all valid bits=0, state=IDLE, mem_req=0, mem_we=0, data_hit=0, rdata=0, counters=0.
//  FSM states: IDLE, REFILL, WRITE.
//  IDLE:
//   - No access: data_hit=1.
//   - Read hit: data_hit=1 combinationally in the same cycle; rdata=array word.
//   - Read miss: data_hit=0; next state REFILL with beat counter=0.
//   - Write (hit or miss): data_hit=0; next state WRITE.
//   - memread and memwrite both set: treated as a read; the write is dropped.
//  REFILL:
//   - mem_req=1, mem_we=0, mem_addr={tag,index,beat,2'b00}; beats issue in order 0..WORDS_PER_LINE-1.
//   - Each mem_ready writes mem_rdata into the array and increments beat; a new address may follow back-to-back.
//   - Last beat sets valid and tag, then returns to IDLE. The lookup now hits, so data_hit=1 in the following cycle.
//   - Read-miss latency = 1 + WORDS_PER_LINE beats (+ ready wait states) + 1.
//  WRITE:
//   - mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata.
//   - On mem_ready: if the line is valid and the tag matches, update the cached word; then go to IDLE.
//   - data_hit=1 only in the mem_ready cycle. A miss does not allocate.
//  mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ready; mem_ready while mem_req=0 is ignored.
//  data_hit=0 in REFILL and WRITE, except the WRITE completion cycle.
//  Reset mid-operation: state forced to IDLE at that edge, so mem_req=0 from the next cycle.
//   The partially refilled line stays invalid. The memory side discards the aborted beat.
//  Beat counter wraps naturally at WORDS_PER_LINE (width = OFFSET_BITS).
// CONFIGURATION
//  DCACHE_STATS_EN defined:
//   - Adds outputs hit_count[31:0] and miss_count[31:0], both wrapping and cleared by rst.
//   - hit_count increments on an IDLE read hit, excluding the post-refill completion cycle.
//   - miss_count increments on the IDLE->REFILL transition. Writes are not counted.
//  DCACHE_STATS_EN undefined: no counters, no extra ports, identical functional behaviour.
// STRUCTURE
//  Package dcache_pkg: state enum (IDLE/REFILL/WRITE), m_ctl bit-position constants, field-width localparams.
//  Sub-module dcache_array: tag/valid/data storage.
//   - Async read by index/offset.
//   - Sync word write; sync valid set and valid clear-all on rst.
//  The top level holds the FSM, beat counter, handshake and optional stats.
// TESTING (INDEX_BITS=4, OFFSET_BITS=2; memory model mem[a]=a^32'hA5A50000 unless written)
//  1. Read miss, ready always 1.
//   - After reset, read 0x40 -> data_hit=0.
//   - mem_addr 0x40,0x44,0x48,0x4C on consecutive beats.
//   - Then data_hit=1 with rdata=0xA5A50040; miss_count=1.
//  2. Read hit: read 0x44 -> data_hit=1 in the same cycle, rdata=0xA5A50044, mem_req never asserted; hit_count=1.
//  3. Write hit then read.
//   - Write 0x48 with 0xDEADBEEF -> one beat with mem_we=1 and mem_wdata=0xDEADBEEF.
//   - data_hit=1 only in the mem_ready cycle.
//   - Then read 0x48 hits, returning 0xDEADBEEF.
//  4. No-allocate and conflict.
//   - Write 0x1000 -> memory write only; read 0x40 still hits.
//   - Read 0x140 (same index, new tag) -> refill evicts the line; read 0x40 then misses.
//  5. Reset mid-refill: assert rst after 2 refill beats -> mem_req=0 next cycle; a later read of 0x40 misses and refills fully.
//  6. Backpressure: hold mem_ready=0 for 10 cycles during REFILL -> data_hit=0 throughout, mem_addr stable, no beat counted.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the MEM-stage data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

  // Controller states: lookup, line refill, write-through beat
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dcache_state_t;

  // Bit positions inside the EX/MEM m_ctl bundle
  localparam int MCTL_BRANCH   = 2;
  localparam int MCTL_MEMREAD  = 1;
  localparam int MCTL_MEMWRITE = 0;

  // Data word width and number of byte-select bits below the word offset
  localparam int WORD_W        = 32;
  localparam int BYTE_SEL_BITS = 2;

  // Tag width is whatever is left of the address above index and offset
  function automatic int tag_width(input int addr_w, input int index_bits, input int offset_bits);
    return addr_w - index_bits - offset_bits - BYTE_SEL_BITS;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Reads are asynchronous so a hit resolves in the same cycle as the lookup.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_W       = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  line_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [WORD_W-1:0]      rd_word,
  input  logic                   wr_en,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [WORD_W-1:0]      wr_word,
  input  logic                   set_en,
  input  logic                   inv_en,
  input  logic [TAG_W-1:0]       set_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = LINES << OFFSET_BITS;

  logic [LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [WORDS];

  // Valid bits: cleared en masse by reset, set when a refill completes,
  // cleared when a refill starts so a half-written line never looks valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (set_en) begin
      valid_reg[line_index] <= 1'b1;
    end else if (inv_en) begin
      valid_reg[line_index] <= 1'b0;
    end
  end

  // Tag is written together with the valid bit at the end of a refill
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_mem[line_index] <= set_tag;
    end
  end

  // Word write for refill beats and write hits
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{line_index, wr_offset}] <= wr_word;
    end
  end

  assign rd_valid = valid_reg[line_index];
  assign rd_tag   = tag_mem[line_index];
  assign rd_word  = data_mem[{line_index, rd_offset}];

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, write-through, no-write-allocate.
// data_hit doubles as the EX/MEM advance enable. Define DCACHE_STATS_EN
// to add hit_count/miss_count outputs.
module mem_stage_dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        m_ctl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              data_hit,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS, OFFSET_BITS);
  localparam logic [OFFSET_BITS-1:0] BEAT_LAST = '1;

  // Address split and access decode; read wins when both controls are set
  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_W-1:0]       tag;
  logic                   rd_acc, wr_acc;
  logic                   unused_ok;

  assign offset    = addr[BYTE_SEL_BITS +: OFFSET_BITS];
  assign index     = addr[BYTE_SEL_BITS + OFFSET_BITS +: INDEX_BITS];
  assign tag       = addr[ADDR_W-1 -: TAG_W];
  assign rd_acc    = m_ctl[MCTL_MEMREAD];
  assign wr_acc    = m_ctl[MCTL_MEMWRITE] & ~m_ctl[MCTL_MEMREAD];
  assign unused_ok = ^{m_ctl[MCTL_BRANCH], addr[BYTE_SEL_BITS-1:0]};

  dcache_state_t          state_reg;
  logic [OFFSET_BITS-1:0] beat_reg, beat_next;
  logic                   mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0]      mem_addr_reg;
  logic [31:0]            mem_wdata_reg;

  logic                   arr_valid;
  logic [TAG_W-1:0]       arr_tag;
  logic [31:0]            arr_word;
  logic                   lookup_hit;
  logic                   arr_wr_en, arr_set_en, arr_inv_en;
  logic [OFFSET_BITS-1:0] arr_wr_offset;
  logic [31:0]            arr_wr_word;
  logic                   idle_read_hit, idle_read_miss, refill_last;

  assign lookup_hit     = arr_valid && (arr_tag == tag);
  assign beat_next      = beat_reg + 1'b1;
  assign idle_read_hit  = (state_reg == IDLE) && rd_acc && lookup_hit;
  assign idle_read_miss = (state_reg == IDLE) && rd_acc && !lookup_hit;
  assign refill_last    = (state_reg == REFILL) && mem_ready && (beat_reg == BEAT_LAST);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .line_index(index),
    .rd_offset (offset),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_word   (arr_word),
    .wr_en     (arr_wr_en),
    .wr_offset (arr_wr_offset),
    .wr_word   (arr_wr_word),
    .set_en    (arr_set_en),
    .inv_en    (arr_inv_en),
    .set_tag   (tag)
  );

  // Pipeline-facing handshake: hits and idle cycles advance, write completes on ready
  always_comb begin
    data_hit = 1'b0;
    rdata    = '0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (rd_acc) begin
            data_hit = lookup_hit;
            rdata    = lookup_hit ? arr_word : '0;
          end else begin
            data_hit = !wr_acc;
          end
        end
        WRITE:   data_hit = mem_ready;
        default: data_hit = 1'b0;
      endcase
    end
  end

  // Array update controls: refill beats, write-hit update, invalidate on refill start
  always_comb begin
    arr_wr_en     = 1'b0;
    arr_set_en    = 1'b0;
    arr_inv_en    = 1'b0;
    arr_wr_offset = offset;
    arr_wr_word   = wdata;
    if (!rst) begin
      case (state_reg)
        IDLE: arr_inv_en = idle_read_miss;
        REFILL: begin
          arr_wr_en     = mem_ready;
          arr_wr_offset = beat_reg;
          arr_wr_word   = mem_rdata;
          arr_set_en    = refill_last;
        end
        WRITE:   arr_wr_en = mem_ready && lookup_hit;
        default: arr_wr_en = 1'b0;
      endcase
    end
  end

  // Controller FSM with registered memory-side request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (idle_read_miss) begin
            state_reg    <= REFILL;
            beat_reg     <= '0;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= {tag, index, {OFFSET_BITS{1'b0}}, {BYTE_SEL_BITS{1'b0}}};
          end else if (wr_acc) begin
            state_reg     <= WRITE;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= {addr[ADDR_W-1:BYTE_SEL_BITS], {BYTE_SEL_BITS{1'b0}}};
            mem_wdata_reg <= wdata;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            beat_reg <= beat_next;
            if (beat_reg == BEAT_LAST) begin
              state_reg   <= IDLE;
              mem_req_reg <= 1'b0;
            end else begin
              mem_addr_reg <= {tag, index, beat_next, {BYTE_SEL_BITS{1'b0}}};
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

`ifdef DCACHE_STATS_EN
  logic        refill_done_reg;
  logic [31:0] hit_count_reg, miss_count_reg;

  // Hit/miss statistics; the lookup right after a refill is the miss completing, not a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_done_reg <= 1'b0;
      hit_count_reg   <= '0;
      miss_count_reg  <= '0;
    end else begin
      refill_done_reg <= refill_last;
      if (idle_read_hit && !refill_done_reg) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (idle_read_miss) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench for mem_stage_dcache with a scoreboard of expected
// memory beats and load data. Counter checks compile only with DCACHE_STATS_EN.
module tb_mem_stage_dcache;

  logic        clk;
  logic        rst;
  logic [2:0]  m_ctl;
  logic [31:0] addr, wdata, rdata;
  logic        data_hit;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  mem_stage_dcache #(
    .INDEX_BITS (4),
    .OFFSET_BITS(2),
    .ADDR_W     (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_ctl    (m_ctl),
    .addr     (addr),
    .wdata    (wdata),
    .data_hit (data_hit),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected beats {we, addr, wdata} and expected load words
  logic [64:0] exp_q [$];
  logic [31:0] exp_rd_q [$];
  logic [31:0] mem_wr [logic [31:0]];
  int n_vec;
  int n_err;
  int hold_cnt;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (mem_wr.exists(a)) return mem_wr[a];
    return a ^ 32'hA5A50000;
  endfunction

  // Start of a cycle: just after the edge, drive the memory response
  task automatic cycle_start();
    @(posedge clk);
    #1;
    if (mem_req === 1'b1) begin
      if (hold_cnt > 0) begin
        mem_ready = 1'b0;
        hold_cnt--;
      end else begin
        mem_ready = 1'b1;
      end
      mem_rdata = model_rd(mem_addr);
    end else begin
      mem_ready = 1'b1;
      mem_rdata = 32'h0;
    end
  endtask

  // Middle of a cycle: score any beat that completes at the coming edge
  task automatic cycle_end();
    logic [64:0] e, o;
    @(negedge clk);
    if (!rst && mem_req === 1'b1 && mem_ready) begin
      n_vec++;
      o = {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got we=%0b addr=%h wdata=%h, required no beat", mem_we, mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL beat: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                   o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]);
        end else begin
          $display("beat we=%0b addr=%h wdata=%h ok", o[64], o[63:32], o[31:0]);
        end
      end
      if (mem_we) mem_wr[mem_addr] = mem_wdata;
    end
  endtask

  task automatic idle_cycle();
    cycle_start();
    m_ctl = 3'b000;
    cycle_end();
  endtask

  // Drive one access and hold it until data_hit, checking latency and load data
  task automatic run_access(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] wd,
                            input int exp_lat, input string name);
    int cyc;
    bit done;
    logic [31:0] er;
    cycle_start();
    m_ctl = ctl; addr = a; wdata = wd;
    cyc = 0; done = 0;
    while (!done && cyc < 60) begin
      cycle_end();
      cyc++;
      if (mem_req === 1'b1 && !mem_ready) begin
        n_vec++;
        if (data_hit !== 1'b0 || exp_q.size() == 0 || mem_addr !== exp_q[0][63:32]) begin
          n_err++;
          $display("FAIL %s_stall: got data_hit=%b mem_addr=%h, required data_hit=0 and stable beat address", name, data_hit, mem_addr);
        end
      end
      if (data_hit === 1'b1) begin
        done = 1;
        if (ctl[1]) begin
          er = exp_rd_q.pop_front();
          n_vec++;
          if (rdata !== er) begin
            n_err++;
            $display("FAIL %s_rdata: got %h, required %h", name, rdata, er);
          end
        end
      end else begin
        cycle_start();
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: got no data_hit in %0d cycles, required completion", name, cyc);
    end else if (cyc != exp_lat || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles with %0d beats pending, required %0d cycles with 0 pending",
               name, cyc, exp_q.size(), exp_lat);
    end else begin
      $display("%s addr=%h ctl=%b done in %0d cycles rdata=%h", name, a, ctl, cyc, rdata);
    end
    exp_q.delete();
  endtask

  task automatic do_read(input logic [2:0] ctl, input logic [31:0] a, input bit miss,
                         input int stall, input string name);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    if (miss) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, base + 32'(4 * k), 32'h0});
    end
    exp_rd_q.push_back(model_rd({a[31:2], 2'b00}));
    hold_cnt = stall;
    run_access(ctl, a, 32'h0, miss ? 6 + stall : 1, name);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string name);
    exp_q.push_back({1'b1, a, d});
    hold_cnt = 0;
    run_access(3'b001, a, d, 2, name);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ctl = 3'b010; addr = 32'h40; wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0; hold_cnt = 0;
    repeat (3) cycle_start();
    cycle_end();
    n_vec++;
    if (data_hit !== 1'b0 || rdata !== 32'h0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got data_hit=%b rdata=%h mem_req=%b mem_we=%b, required 0/0/0/0", data_hit, rdata, mem_req, mem_we);
    end else $display("reset state ok");
`ifdef DCACHE_STATS_EN
    n_vec++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counts: got hit=%0d miss=%0d, required 0/0", hit_count, miss_count);
    end
`endif
    cycle_start();
    rst = 1'b0; m_ctl = 3'b000;
    cycle_end();
    n_vec++;
    if (data_hit !== 1'b1) begin
      n_err++;
      $display("FAIL idle_hit: got %b, required 1", data_hit);
    end
  endtask

  task automatic test_read_miss();
    do_read(3'b010, 32'h40, 1, 0, "read_miss_40");
    n_vec++;
    if (rdata !== 32'hA5A50040) begin
      n_err++;
      $display("FAIL read_miss_value: got %h, required a5a50040", rdata);
    end
    idle_cycle();
`ifdef DCACHE_STATS_EN
    n_vec++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      n_err++;
      $display("FAIL miss_count: got hit=%0d miss=%0d, required 0/1", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_read_hit();
    do_read(3'b010, 32'h44, 0, 0, "read_hit_44");
    n_vec++;
    if (mem_req !== 1'b0 || rdata !== 32'hA5A50044) begin
      n_err++;
      $display("FAIL read_hit_value: got mem_req=%b rdata=%h, required 0 and a5a50044", mem_req, rdata);
    end
    idle_cycle();
`ifdef DCACHE_STATS_EN
    n_vec++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      n_err++;
      $display("FAIL hit_count: got hit=%0d miss=%0d, required 1/1", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_write_hit();
    do_write(32'h48, 32'hDEADBEEF, "write_hit_48");
    do_read(3'b010, 32'h48, 0, 0, "read_after_write_48");
    n_vec++;
    if (rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_hit_value: got %h, required deadbeef", rdata);
    end
  endtask

  task automatic test_no_allocate_conflict();
    do_write(32'h1000, 32'h12345678, "write_miss_1000");
    do_read(3'b010, 32'h40, 0, 0, "still_hit_40");
    do_read(3'b010, 32'h1000, 1, 0, "read_noalloc_1000");
    do_read(3'b010, 32'h140, 1, 0, "conflict_140");
    do_read(3'b010, 32'h40, 1, 0, "evicted_40");
    do_read(3'b010, 32'h48, 0, 0, "refilled_48");
    n_vec++;
    if (rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL refill_after_write: got %h, required deadbeef", rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_read(3'b010, 32'h4C, 0, 0, "b2b_hit_4c");
    do_read(3'b011, 32'h44, 0, 0, "rd_wr_both_44");
    do_read(3'b110, 32'h40, 0, 0, "branch_ignored_40");
    do_read(3'b010, 32'h1004, 0, 0, "b2b_hit_1004");
  endtask

  task automatic test_reset_mid_refill();
    exp_q.push_back({1'b0, 32'h80, 32'h0});
    exp_q.push_back({1'b0, 32'h84, 32'h0});
    hold_cnt = 0;
    cycle_start();
    m_ctl = 3'b010; addr = 32'h80;
    repeat (3) begin
      cycle_end();
      n_vec++;
      if (data_hit !== 1'b0) begin
        n_err++;
        $display("FAIL abort_stall: got data_hit=%b, required 0", data_hit);
      end
      cycle_start();
    end
    rst = 1'b1;
    cycle_end();
    cycle_start();
    rst = 1'b0; m_ctl = 3'b000;
    cycle_end();
    n_vec++;
    if (mem_req !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_req: got mem_req=%b pending=%0d, required 0/0", mem_req, exp_q.size());
    end else $display("reset mid-refill: mem_req dropped");
    exp_q.delete();
    do_read(3'b010, 32'h40, 1, 0, "post_reset_40");
    do_read(3'b010, 32'h84, 1, 0, "post_reset_84");
  endtask

  task automatic test_backpressure();
    do_read(3'b010, 32'h200, 1, 10, "stall_200");
    do_read(3'b010, 32'h20C, 0, 0, "stall_hit_20c");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_no_allocate_conflict();
    test_back_to_back();
    test_reset_mid_refill();
    test_backpressure();
    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
